// File: rtl/fd_n_monitor.sv
// Divide-by-N strobe monitor: measures DIV_N falling-edge spacing, declares lock, flags sticky errors.
// Optional min/max tracking of measured_n is enabled with macro FD_MON_MINMAX_EN.
module fd_n_monitor #(
   parameter int N_W      = 4,
   parameter int CNT_W    = 5,
   parameter int LOCK_CNT = 4
) (
   input  logic             clk_out,
   input  logic             rst,
   input  logic             en,
   input  logic             DIV_N,
   input  logic [N_W-1:0]   n_expected,
   input  logic             err_clr,
   output logic [CNT_W-1:0] measured_n,
   output logic             period_valid,
   output logic             lock,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] min_n,
   output logic [CNT_W-1:0] max_n,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_ACQ, S_MEAS, S_LOCKED} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);

   state_t           r_state;
   logic             r_div_d;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_match;
   logic [N_W-1:0]   r_n_q;
   logic [CNT_W-1:0] r_measured;
   logic             r_pv;
   logic             r_lock;
   logic             r_err;
   logic [1:0]       r_err_code;

   logic             w_ev;
   logic             w_n_chg;
   logic [CNT_W-1:0] w_n_ext;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_measuring;
   logic             w_meas_start;
   logic             w_meas_ev;

   assign w_ev         = r_div_d & ~DIV_N;
   assign w_n_chg      = (n_expected != r_n_q);
   assign w_n_ext      = CNT_W'(n_expected);
   assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
   assign w_measuring  = (r_state == S_MEAS) || (r_state == S_LOCKED);
   assign w_meas_start = en && !w_n_chg && !w_measuring && w_ev;
   assign w_meas_ev    = en && !w_n_chg && w_measuring && w_ev;

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_div_d    <= 1'b1;
         r_cnt      <= '0;
         r_match    <= '0;
         r_n_q      <= '0;
         r_measured <= '0;
         r_pv       <= 1'b0;
         r_lock     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else begin
         r_div_d <= DIV_N;
         r_n_q   <= n_expected;
         r_pv    <= 1'b0;
         // A clear is overridden by any error raised later in this block.
         if (err_clr) r_err <= 1'b0;
         if (!en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_match <= '0;
            r_lock  <= 1'b0;
         end else if (w_n_chg) begin
            r_state <= S_ACQ;
            r_cnt   <= '0;
            r_match <= '0;
            r_lock  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_ACQ: begin
                  if (w_ev) begin
                     r_cnt   <= 1;
                     r_state <= S_MEAS;
                  end else begin
                     r_state <= S_ACQ;
                     r_cnt   <= w_cnt_inc;
                  end
               end
               default: begin
                  if (w_ev) begin
                     r_measured <= r_cnt;
                     r_pv       <= 1'b1;
                     r_cnt      <= 1;
                     if (r_cnt == w_n_ext) begin
                        if (r_state == S_MEAS) begin
                           r_match <= r_match + 1'b1;
                           if (r_match == LOCK_LAST) begin
                              r_state <= S_LOCKED;
                              r_lock  <= 1'b1;
                           end
                        end
                     end else begin
                        r_match <= '0;
                        if (r_state == S_LOCKED) begin
                           r_state    <= S_MEAS;
                           r_lock     <= 1'b0;
                           r_err      <= 1'b1;
                           r_err_code <= 2'b01;
                        end
                     end
                  end else if (r_cnt == CNT_MAX) begin
                     // Missing strobe: counter stays saturated while reacquiring.
                     r_state    <= S_ACQ;
                     r_match    <= '0;
                     r_lock     <= 1'b0;
                     r_err      <= 1'b1;
                     r_err_code <= 2'b10;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
            endcase
         end
      end
   end

`ifdef FD_MON_MINMAX_EN
   logic             r_mm_first;
   logic [CNT_W-1:0] r_min;
   logic [CNT_W-1:0] r_max;

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         r_mm_first <= 1'b0;
         r_min      <= '0;
         r_max      <= '0;
      end else if (w_meas_start) begin
         r_mm_first <= 1'b1;
      end else if (w_meas_ev) begin
         r_mm_first <= 1'b0;
         if (r_mm_first || r_cnt < r_min) r_min <= r_cnt;
         if (r_mm_first || r_cnt > r_max) r_max <= r_cnt;
      end
   end

   assign min_n = r_min;
   assign max_n = r_max;
`else
   assign min_n = '0;
   assign max_n = '0;
`endif

   assign measured_n   = r_measured;
   assign period_valid = r_pv;
   assign lock         = r_lock;
   assign err          = r_err;
   assign err_code     = r_err_code;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_fd_n_monitor.sv
// Bench for fd_n_monitor: directed scenarios plus random strobe trains, checked against an
// edge-timestamp reference model.
module tb_fd_n_monitor;

   logic       clk_out = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       div_n = 1'b1;
   logic [3:0] n_exp = 4'd0;
   logic       err_clr = 1'b0;
   logic [4:0] measured_n;
   logic       period_valid;
   logic       lock;
   logic       err;
   logic [1:0] err_code;
   logic [4:0] min_n;
   logic [4:0] max_n;
   logic [1:0] dbg_state;

   int total = 0;
   int bad = 0;

   fd_n_monitor #(.N_W(4), .CNT_W(5), .LOCK_CNT(4)) dut (
      .clk_out(clk_out), .rst(rst), .en(en), .DIV_N(div_n), .n_expected(n_exp),
      .err_clr(err_clr), .measured_n(measured_n), .period_valid(period_valid),
      .lock(lock), .err(err), .err_code(err_code), .min_n(min_n), .max_n(max_n),
      .dbg_state(dbg_state)
   );

   initial forever #5 clk_out = ~clk_out;

   // Reference model: works from edge timestamps, not a cycle counter.
   int         k;
   int         m_last;
   bit         m_prev;
   int         m_phase;   // 0 disabled, 1 waiting for first edge, 2 measuring
   bit         m_lock;
   int         m_matches;
   int         m_meas;
   bit         m_pv;
   bit         m_err;
   logic [1:0] m_code;
   logic [3:0] m_nq;

   function automatic void model_reset();
      m_prev = 1'b1; m_phase = 0; m_lock = 0; m_matches = 0; m_meas = 0;
      m_pv = 0; m_err = 0; m_code = 2'b00; m_nq = 4'd0;
   endfunction

   function automatic void model_step();
      bit         ev;
      bit         chg;
      int         p;
      bit         new_err;
      logic [1:0] new_code;
      k++;
      ev = m_prev && !div_n;
      m_prev = div_n;
      chg = (n_exp != m_nq);
      m_nq = n_exp;
      m_pv = 0; new_err = 0; new_code = 2'b00;
      if (!en) begin
         m_phase = 0; m_lock = 0; m_matches = 0;
      end else if (chg) begin
         m_phase = 1; m_lock = 0; m_matches = 0;
      end else if (m_phase != 2) begin
         if (ev) begin m_phase = 2; m_last = k; end
         else m_phase = 1;
      end else if (ev) begin
         p = k - m_last;
         m_last = k;
         m_meas = p;
         m_pv = 1;
         if (p == int'(n_exp)) begin
            m_matches++;
            if (m_matches >= 4) m_lock = 1;
         end else begin
            m_matches = 0;
            if (m_lock) begin m_lock = 0; new_err = 1; new_code = 2'b01; end
         end
      end else if (k - m_last >= 31) begin
         m_phase = 1; m_lock = 0; m_matches = 0; new_err = 1; new_code = 2'b10;
      end
      if (err_clr) m_err = 0;
      if (new_err) begin m_err = 1; m_code = new_code; end
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_all();
      int st;
      st = (m_phase == 0) ? 0 : (m_phase == 1) ? 1 : (m_lock ? 3 : 2);
      chk("measured_n", 32'(measured_n), 32'(m_meas));
      chk("period_valid", 32'(period_valid), 32'(m_pv));
      chk("lock", 32'(lock), 32'(m_lock));
      chk("err", 32'(err), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("state", 32'(dbg_state), 32'(st));
`ifndef FD_MON_MINMAX_EN
      chk("min_n", 32'(min_n), 0);
      chk("max_n", 32'(max_n), 0);
`endif
   endtask

   task automatic step();
      @(posedge clk_out);
      model_step();
      #1;
      check_all();
   endtask

   task automatic period(input int p, input int low, input bit clr);
      for (int i = 0; i < p; i++) begin
         div_n = (i < low) ? 1'b0 : 1'b1;
         err_clr = (i == 0) ? clr : 1'b0;
         step();
      end
      err_clr = 1'b0;
   endtask

   initial begin
      int sel;
      int p;
      k = 0; m_last = 0;
      model_reset();
      #1;
      chk("rst_measured", 32'(measured_n), 0);
      chk("rst_pv", 32'(period_valid), 0);
      chk("rst_lock", 32'(lock), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_code", 32'(err_code), 0);
      chk("rst_state", 32'(dbg_state), 0);
      @(posedge clk_out); @(posedge clk_out); #1;
      n_exp = 4'd5;
      rst = 1'b0;
      model_reset();
      step();

      // Lock at N=5 with one-cycle strobes
      en = 1'b1;
      repeat (5) period(5, 1, 0);
      chk("lock_n5", 32'(lock), 1);
      chk("meas_n5", 32'(measured_n), 5);
      chk("noerr_n5", 32'(err), 0);

      // One long period while locked, then relock
      period(6, 1, 0);
      period(5, 1, 0);
      chk("mis_lock", 32'(lock), 0);
      chk("mis_err", 32'(err), 1);
      chk("mis_code", 32'(err_code), 1);
      chk("mis_meas", 32'(measured_n), 6);
      repeat (4) period(5, 1, 0);
      chk("relock", 32'(lock), 1);
      chk("err_sticky", 32'(err), 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("err_cleared", 32'(err), 0);

      // Missing strobes while locked
      div_n = 1'b1;
      repeat (35) step();
      chk("tmo_err", 32'(err), 1);
      chk("tmo_code", 32'(err_code), 2);
      chk("tmo_lock", 32'(lock), 0);
      chk("tmo_state", 32'(dbg_state), 1);

      // Wide low pulses at N=8
      en = 1'b0; step();
      chk("en_off_lock", 32'(lock), 0);
      n_exp = 4'd8; step();
      en = 1'b1;
      repeat (5) period(8, 3, 0);
      chk("lock_n8", 32'(lock), 1);
      chk("meas_n8", 32'(measured_n), 8);

      // Ratio change while locked
      err_clr = 1'b1; step(); err_clr = 1'b0;
      en = 1'b0; step(); n_exp = 4'd5; step(); en = 1'b1;
      repeat (5) period(5, 1, 0);
      chk("lock_pre_chg", 32'(lock), 1);
      n_exp = 4'd7; step();
      chk("chg_lock", 32'(lock), 0);
      chk("chg_err", 32'(err), 0);
      repeat (5) period(7, 2, 0);
      chk("relock_n7", 32'(lock), 1);

      // Clear coinciding with a mismatch
      period(9, 1, 0);
      period(7, 1, 1);
      chk("clr_vs_set", 32'(err), 1);
      period(7, 1, 0);

      // Random strobe trains
      for (int r = 0; r < 60; r++) begin
         sel = $urandom_range(0, 15);
         if (sel == 0) begin
            en = 1'b0; step(); step(); en = 1'b1;
         end else if (sel == 1) begin
            n_exp = 4'($urandom_range(3, 9));
         end else if (sel == 2) begin
            div_n = 1'b1; repeat (33) step();
         end else begin
            p = (sel < 11) ? int'(n_exp) : $urandom_range(2, 12);
            period(p, $urandom_range(1, p - 1), ($urandom_range(0, 3) == 0));
         end
      end

      // Asynchronous reset in the middle of measurement
      en = 1'b1; n_exp = 4'd5;
      repeat (3) period(5, 1, 0);
      period(6, 1, 0);
      period(5, 1, 0);
      div_n = 1'b1; step(); step();
      rst = 1'b1;
      #1;
      chk("arst_measured", 32'(measured_n), 0);
      chk("arst_lock", 32'(lock), 0);
      chk("arst_err", 32'(err), 0);
      chk("arst_code", 32'(err_code), 0);
      chk("arst_state", 32'(dbg_state), 0);
      @(posedge clk_out); #1;
      rst = 1'b0;
      model_reset();
      repeat (6) period(5, 1, 0);
      chk("post_rst_lock", 32'(lock), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
